// File: rtl/branch_resolve_ctrl_if.sv
// ID-stage branch resolution bundle: decoded branch, comparator, hazard inputs
// and the PC / pipeline control / statistics outputs of branch_resolve_ctrl.
interface branch_resolve_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             is_beq;
  logic             is_bne;
  logic             zero;
  logic [31:0]      branch_target;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             mem_reg_write;
  logic             mem_mem_read;
  logic [4:0]       mem_rd;
  logic [31:0]      pc;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             fwd_a;
  logic             fwd_b;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output is_beq, is_bne, zero, branch_target, id_rs, id_rt,
           ex_reg_write, ex_mem_read, ex_rd, mem_reg_write, mem_mem_read, mem_rd,
    input  pc, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
           branch_cnt, taken_cnt
  );

  modport slave (
    input  is_beq, is_bne, zero, branch_target, id_rs, id_rt,
           ex_reg_write, ex_mem_read, ex_rd, mem_reg_write, mem_mem_read, mem_rd,
    output pc, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
           branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ID-stage beq/bne resolution: owns the PC, applies branch stall rules, drives
// comparator forwarding selects and keeps saturating branch statistics.
module branch_resolve_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_resolve_ctrl_if.slave bus
);
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] STALL1 = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q;
  logic [0:0]       state_next;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic br;
  logic rs_nz;
  logic rt_nz;
  logic ex_rs_hit;
  logic ex_rt_hit;
  logic mem_rs_hit;
  logic mem_rt_hit;
  logic exl;
  logic exa;
  logic meml;
  logic stall;
  logic taken;

  // Register $zero never carries a dependency, so matches against r0 are ignored.
  assign br    = bus.is_beq | bus.is_bne;
  assign rs_nz = bus.id_rs != 5'd0;
  assign rt_nz = bus.id_rt != 5'd0;

  assign ex_rs_hit  = rs_nz & (bus.ex_rd == bus.id_rs);
  assign ex_rt_hit  = rt_nz & (bus.ex_rd == bus.id_rt);
  assign mem_rs_hit = rs_nz & (bus.mem_rd == bus.id_rs);
  assign mem_rt_hit = rt_nz & (bus.mem_rd == bus.id_rt);

  assign exl  = br & bus.ex_reg_write & bus.ex_mem_read & (ex_rs_hit | ex_rt_hit);
  assign exa  = br & bus.ex_reg_write & ~bus.ex_mem_read & (ex_rs_hit | ex_rt_hit);
  assign meml = br & bus.mem_reg_write & bus.mem_mem_read & (mem_rs_hit | mem_rt_hit);

  assign stall = (state_q == STALL1) | exl | exa | meml;
  assign taken = (bus.is_beq & bus.zero) | (bus.is_bne & ~bus.zero);

  assign bus.fwd_a = br & bus.mem_reg_write & ~bus.mem_mem_read & mem_rs_hit;
  assign bus.fwd_b = br & bus.mem_reg_write & ~bus.mem_mem_read & mem_rt_hit;

  assign bus.ifid_write  = ~stall;
  assign bus.idex_bubble = stall;
  assign bus.ifid_flush  = ~stall & taken;

  // A load in EX needs a second stall cycle before its data reaches the bypass.
  always_comb begin
    state_next = RUN;
    if (state_q == RUN && exl) begin
      state_next = STALL1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q <= state_next;
      if (!stall) begin
        pc_q <= taken ? bus.branch_target : pc_q + 32'd4;
        if (br && branch_cnt_q != '1) begin
          branch_cnt_q <= branch_cnt_q + CNT_ONE;
        end
        if (taken && taken_cnt_q != '1) begin
          taken_cnt_q <= taken_cnt_q + CNT_ONE;
        end
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.branch_cnt = branch_cnt_q;
  assign bus.taken_cnt  = taken_cnt_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl, built with 4-bit
// counters so saturation is reachable in a short run.
module tb_branch_resolve_ctrl;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_resolve_ctrl_if #(.CNT_W(CNT_W)) bus ();

  branch_resolve_ctrl #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; combinational outputs are
  // sampled 4 units later, on the falling edge.
  task automatic applyStimulus(
    input logic        beq,
    input logic        bne,
    input logic        zero,
    input logic [31:0] target,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic        exw,
    input logic        exr,
    input logic [4:0]  exrd,
    input logic        memw,
    input logic        memr,
    input logic [4:0]  memrd
  );
    bus.is_beq        = beq;
    bus.is_bne        = bne;
    bus.zero          = zero;
    bus.branch_target = target;
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.ex_reg_write  = exw;
    bus.ex_mem_read   = exr;
    bus.ex_rd         = exrd;
    bus.mem_reg_write = memw;
    bus.mem_mem_read  = memr;
    bus.mem_rd        = memrd;
    #4;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 32'h0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    #8;
    checkOutput("reset_pc", bus.pc, 32'h0);
    checkOutput("reset_branch_cnt", 32'(bus.branch_cnt), 32'h0);
    checkOutput("reset_taken_cnt", 32'(bus.taken_cnt), 32'h0);
    checkOutput("reset_ifid_write", 32'(bus.ifid_write), 32'h1);
    checkOutput("reset_ifid_flush", 32'(bus.ifid_flush), 32'h0);
    checkOutput("reset_idex_bubble", 32'(bus.idex_bubble), 32'h0);
    checkOutput("reset_fwd_a", 32'(bus.fwd_a), 32'h0);
    checkOutput("reset_fwd_b", 32'(bus.fwd_b), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) nextCycle();
    checkOutput("pc_after_3", bus.pc, 32'h0000_000C);
    repeat (13) nextCycle();
    checkOutput("pc_at_40", bus.pc, 32'h0000_0040);

    // Not-taken beq, no hazard
    applyStimulus(1, 0, 0, 32'h0000_0800, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 5'd0);
    checkOutput("nt_flush", 32'(bus.ifid_flush), 32'h0);
    checkOutput("nt_ifid_write", 32'(bus.ifid_write), 32'h1);
    checkOutput("nt_bubble", 32'(bus.idex_bubble), 32'h0);
    nextCycle();
    checkOutput("nt_pc", bus.pc, 32'h0000_0044);
    checkOutput("nt_branch_cnt", 32'(bus.branch_cnt), 32'h1);
    checkOutput("nt_taken_cnt", 32'(bus.taken_cnt), 32'h0);

    // Taken bne
    applyStimulus(0, 1, 0, 32'h0000_0100, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 5'd0);
    checkOutput("tk_flush", 32'(bus.ifid_flush), 32'h1);
    nextCycle();
    checkOutput("tk_pc", bus.pc, 32'h0000_0100);
    checkOutput("tk_taken_cnt", 32'(bus.taken_cnt), 32'h1);
    checkOutput("tk_branch_cnt", 32'(bus.branch_cnt), 32'h2);

    // Load-use on rs: two stall cycles, then a taken beq
    applyStimulus(1, 0, 1, 32'h0000_0200, 5'd8, 5'd3, 1, 1, 5'd8, 0, 0, 5'd0);
    checkOutput("lu1_ifid_write", 32'(bus.ifid_write), 32'h0);
    checkOutput("lu1_bubble", 32'(bus.idex_bubble), 32'h1);
    checkOutput("lu1_flush", 32'(bus.ifid_flush), 32'h0);
    nextCycle();
    checkOutput("lu1_pc_held", bus.pc, 32'h0000_0100);
    applyStimulus(1, 0, 1, 32'h0000_0200, 5'd8, 5'd3, 0, 0, 5'd0, 0, 0, 5'd0);
    checkOutput("lu2_ifid_write", 32'(bus.ifid_write), 32'h0);
    checkOutput("lu2_bubble", 32'(bus.idex_bubble), 32'h1);
    nextCycle();
    checkOutput("lu2_pc_held", bus.pc, 32'h0000_0100);
    checkOutput("lu2_branch_cnt_held", 32'(bus.branch_cnt), 32'h2);
    applyStimulus(1, 0, 1, 32'h0000_0200, 5'd8, 5'd3, 0, 0, 5'd0, 0, 0, 5'd0);
    checkOutput("lu3_ifid_write", 32'(bus.ifid_write), 32'h1);
    checkOutput("lu3_fwd_a", 32'(bus.fwd_a), 32'h0);
    checkOutput("lu3_flush", 32'(bus.ifid_flush), 32'h1);
    nextCycle();
    checkOutput("lu3_pc", bus.pc, 32'h0000_0200);
    checkOutput("lu3_branch_cnt", 32'(bus.branch_cnt), 32'h3);
    checkOutput("lu3_taken_cnt", 32'(bus.taken_cnt), 32'h2);

    // ALU dependency on rt: one stall, then forwarded from MEM
    applyStimulus(0, 1, 1, 32'h0000_0900, 5'd4, 5'd9, 1, 0, 5'd9, 0, 0, 5'd0);
    checkOutput("alu1_ifid_write", 32'(bus.ifid_write), 32'h0);
    checkOutput("alu1_bubble", 32'(bus.idex_bubble), 32'h1);
    nextCycle();
    checkOutput("alu1_pc_held", bus.pc, 32'h0000_0200);
    applyStimulus(0, 1, 1, 32'h0000_0900, 5'd4, 5'd9, 0, 0, 5'd0, 1, 0, 5'd9);
    checkOutput("alu2_fwd_b", 32'(bus.fwd_b), 32'h1);
    checkOutput("alu2_fwd_a", 32'(bus.fwd_a), 32'h0);
    checkOutput("alu2_ifid_write", 32'(bus.ifid_write), 32'h1);
    checkOutput("alu2_flush", 32'(bus.ifid_flush), 32'h0);
    nextCycle();
    checkOutput("alu2_pc", bus.pc, 32'h0000_0204);
    checkOutput("alu2_branch_cnt", 32'(bus.branch_cnt), 32'h4);

    // r0 match never stalls
    applyStimulus(1, 0, 0, 32'h0000_0900, 5'd0, 5'd6, 1, 0, 5'd0, 0, 0, 5'd0);
    checkOutput("r0_ifid_write", 32'(bus.ifid_write), 32'h1);
    checkOutput("r0_bubble", 32'(bus.idex_bubble), 32'h0);
    nextCycle();
    checkOutput("r0_pc", bus.pc, 32'h0000_0208);
    checkOutput("r0_branch_cnt", 32'(bus.branch_cnt), 32'h5);

    // Load in MEM: one stall, no forwarding of load data
    applyStimulus(1, 0, 1, 32'h0000_0300, 5'd5, 5'd7, 0, 0, 5'd0, 1, 1, 5'd5);
    checkOutput("meml_ifid_write", 32'(bus.ifid_write), 32'h0);
    checkOutput("meml_fwd_a", 32'(bus.fwd_a), 32'h0);
    nextCycle();
    checkOutput("meml_pc_held", bus.pc, 32'h0000_0208);
    applyStimulus(1, 0, 1, 32'h0000_0300, 5'd5, 5'd7, 0, 0, 5'd0, 0, 0, 5'd0);
    checkOutput("meml_resolve", 32'(bus.ifid_write), 32'h1);
    nextCycle();
    checkOutput("meml_pc", bus.pc, 32'h0000_0300);
    checkOutput("meml_taken_cnt", 32'(bus.taken_cnt), 32'h3);

    // Saturation: 17 taken branches, last one targets the top of memory
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 0, 1, (i == 16) ? 32'hFFFF_FFFC : 32'h0000_0400,
                    5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 5'd0);
      nextCycle();
    end
    checkOutput("sat_branch_cnt", 32'(bus.branch_cnt), 32'hF);
    checkOutput("sat_taken_cnt", 32'(bus.taken_cnt), 32'hF);
    checkOutput("sat_pc_top", bus.pc, 32'hFFFF_FFFC);
    idle();
    nextCycle();
    checkOutput("wrap_pc", bus.pc, 32'h0000_0000);

    // Reset asserted during STALL1 aborts the stall
    applyStimulus(1, 0, 1, 32'h0000_0500, 5'd8, 5'd3, 1, 1, 5'd8, 0, 0, 5'd0);
    nextCycle();
    idle();
    checkOutput("stall1_active", 32'(bus.ifid_write), 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_pc", bus.pc, 32'h0);
    checkOutput("midrst_branch_cnt", 32'(bus.branch_cnt), 32'h0);
    checkOutput("midrst_ifid_write", 32'(bus.ifid_write), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    idle();
    checkOutput("postrst_ifid_write", 32'(bus.ifid_write), 32'h1);
    checkOutput("postrst_bubble", 32'(bus.idex_bubble), 32'h0);
    nextCycle();
    checkOutput("postrst_pc", bus.pc, 32'h0000_0008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
